// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completed results from the int, mult, div
// and mem units in small per-unit FIFOs and broadcasts one result per cycle on
// a registered CDB, granting round-robin among the non-empty FIFOs.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,

    input  logic              i_int_valid,
    input  logic [TAG_W-1:0]  i_int_tag,
    input  logic [DATA_W-1:0] i_int_data,
    input  logic              i_int_branch,
    input  logic              i_int_br_taken,
    output logic              o_int_ready,

    input  logic              i_mult_valid,
    input  logic [TAG_W-1:0]  i_mult_tag,
    input  logic [DATA_W-1:0] i_mult_data,
    input  logic              i_mult_branch,
    input  logic              i_mult_br_taken,
    output logic              o_mult_ready,

    input  logic              i_div_valid,
    input  logic [TAG_W-1:0]  i_div_tag,
    input  logic [DATA_W-1:0] i_div_data,
    input  logic              i_div_branch,
    input  logic              i_div_br_taken,
    output logic              o_div_ready,

    input  logic              i_mem_valid,
    input  logic [TAG_W-1:0]  i_mem_tag,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_branch,
    input  logic              i_mem_br_taken,
    output logic              o_mem_ready,

    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = TAG_W + DATA_W + 2;

    typedef enum logic [1:0] {
        SRC_INT  = 2'd0,
        SRC_MULT = 2'd1,
        SRC_DIV  = 2'd2,
        SRC_MEM  = 2'd3
    } src_e;

    logic [3:0]       push_valid;
    logic [ENT_W-1:0] push_entry [4];
    logic [3:0]       ready;
    logic [3:0]       push;
    logic [3:0]       pop;

    logic [ENT_W-1:0] fifo_mem [4][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr [4];
    logic [PTR_W-1:0] wr_ptr [4];
    logic [CNT_W-1:0] count  [4];

    src_e             rr_ptr;
    src_e             grant_idx;
    src_e             cand;
    logic             grant_valid;
    logic [ENT_W-1:0] head_entry;

    assign o_int_ready  = ready[SRC_INT];
    assign o_mult_ready = ready[SRC_MULT];
    assign o_div_ready  = ready[SRC_DIV];
    assign o_mem_ready  = ready[SRC_MEM];

    // Gather the four unit interfaces into indexed form; entry = {branch, taken, tag, data}
    always_comb begin
        push_valid    = {i_mem_valid, i_div_valid, i_mult_valid, i_int_valid};
        push_entry[0] = {i_int_branch,  i_int_br_taken,  i_int_tag,  i_int_data};
        push_entry[1] = {i_mult_branch, i_mult_br_taken, i_mult_tag, i_mult_data};
        push_entry[2] = {i_div_branch,  i_div_br_taken,  i_div_tag,  i_div_data};
        push_entry[3] = {i_mem_branch,  i_mem_br_taken,  i_mem_tag,  i_mem_data};
    end

    // Ready depends on the registered count only, so a pop never frees a slot in the same cycle
    always_comb begin
        for (int unsigned u = 0; u < 4; u++) begin
            ready[u] = (count[u] < CNT_W'(FIFO_DEPTH));
            push[u]  = push_valid[u] & ready[u];
        end
    end

    // Round-robin search from rr_ptr, wrapping, for the first non-empty FIFO
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        pop         = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = src_e'(rr_ptr + 2'(k));
            if (!grant_valid && (count[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
        head_entry = fifo_mem[grant_idx][rd_ptr[grant_idx]];
    end

    // Per-unit FIFO storage and pointers; flush empties everything and discards same-cycle pushes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned u = 0; u < 4; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
                for (int unsigned d = 0; d < FIFO_DEPTH; d++) begin
                    fifo_mem[u][d] <= '0;
                end
            end
        end else if (i_flush) begin
            for (int unsigned u = 0; u < 4; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            for (int unsigned u = 0; u < 4; u++) begin
                if (push[u]) begin
                    fifo_mem[u][wr_ptr[u]] <= push_entry[u];
                    wr_ptr[u]              <= wr_ptr[u] + PTR_W'(1);
                end
                if (pop[u]) begin
                    rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
                end
                count[u] <= count[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
            end
        end
    end

    // Registered CDB broadcast and round-robin pointer advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            rr_ptr           <= SRC_INT;
        end else if (i_flush || !grant_valid) begin
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end else begin
            cdb_valid <= 1'b1;
            {cdb_branch, cdb_branch_taken, cdb_tag, cdb_data} <= head_entry;
            rr_ptr    <= src_e'(grant_idx + 2'd1);
        end
    end

endmodule
